// File: rtl/frame_pixel_server.sv
// frame_pixel_server: on-chip responder for the gray-scale framebuffer pixel
// protocol. It follows the VGA generator's next_pixel/frame_reset strobes and
// serves a 4-bit pixel from a small writable tile that repeats across the screen.
// Optional build macro FBSRV_TESTPATTERN_EN adds pattern_sel, which selects an
// XOR test pattern instead of the tile memory.
module frame_pixel_server #(
  parameter int unsigned H_PIXELS   = 640,
  parameter int unsigned V_LINES    = 480,
  parameter int unsigned TILE_LOG2  = 3,
  parameter int unsigned SCALE_LOG2 = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   frame_next_pixel,
  input  logic                   frame_reset,
`ifdef FBSRV_TESTPATTERN_EN
  input  logic                   pattern_sel,
`endif
  input  logic                   wr_en,
  input  logic [2*TILE_LOG2-1:0] wr_addr,
  input  logic [3:0]             wr_data,
  output logic [3:0]             frame_pixel,
  output logic                   line_end,
  output logic                   frame_end
);

  localparam int unsigned XW    = $clog2(H_PIXELS);
  localparam int unsigned YW    = $clog2(V_LINES);
  localparam int unsigned AW    = 2 * TILE_LOG2;
  localparam int unsigned DEPTH = 1 << AW;

  logic [XW-1:0]        x, nx_c;
  logic [YW-1:0]        y, ny_c;
  logic                 line_wrap_c, frame_wrap_c;
  logic [TILE_LOG2-1:0] rd_row_c, rd_col_c;
  logic [AW-1:0]        rd_addr_c;
  logic [3:0]           pix_c;
  logic [3:0]           mem [DEPTH];

  // Next scan position; frame_reset wins over a same-cycle next_pixel.
  always_comb begin
    nx_c         = x;
    ny_c         = y;
    line_wrap_c  = 1'b0;
    frame_wrap_c = 1'b0;
    if (frame_reset) begin
      nx_c = '0;
      ny_c = '0;
    end else if (frame_next_pixel) begin
      if (x == XW'(H_PIXELS - 1)) begin
        nx_c        = '0;
        line_wrap_c = 1'b1;
        if (y == YW'(V_LINES - 1)) begin
          ny_c         = '0;
          frame_wrap_c = 1'b1;
        end else begin
          ny_c = y + YW'(1);
        end
      end else begin
        nx_c = x + XW'(1);
      end
    end
  end

  // Tile address of the next position; truncation makes the tile repeat.
  always_comb begin
    rd_row_c  = TILE_LOG2'(ny_c >> SCALE_LOG2);
    rd_col_c  = TILE_LOG2'(nx_c >> SCALE_LOG2);
    rd_addr_c = {rd_row_c, rd_col_c};
  end

  // Pixel source: memory with same-cycle write forwarding, or the test pattern.
  always_comb begin
    pix_c = mem[rd_addr_c];
    if (wr_en && (wr_addr == rd_addr_c)) begin
      pix_c = wr_data;
    end
`ifdef FBSRV_TESTPATTERN_EN
    if (pattern_sel) begin
      pix_c = 4'(nx_c >> SCALE_LOG2) ^ 4'(ny_c >> SCALE_LOG2);
    end
`endif
  end

  // Tile memory write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Position, pixel and wrap-pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x           <= '0;
      y           <= '0;
      frame_pixel <= '0;
      line_end    <= 1'b0;
      frame_end   <= 1'b0;
    end else begin
      x           <= nx_c;
      y           <= ny_c;
      frame_pixel <= pix_c;
      line_end    <= line_wrap_c;
      frame_end   <= frame_wrap_c;
    end
  end

endmodule
